// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings, FSM state types and small response helpers for the HP0 stand-in slave.
package axi3_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_FETCH,
    R_DATA
  } r_state_t;

  // DECERR outranks SLVERR, which outranks OKAY.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic beat_out_of_range(input logic [31:0] addr, input logic [31:0] base,
                                             input logic [31:0] depth);
    logic [31:0] offset;
    offset = (addr - base) >> 3;
    return (addr < base) || (offset >= depth);
  endfunction

endpackage

// File: rtl/sdp_bram_be.sv
// Simple dual-port 64-bit RAM: byte-enabled write port, registered read port, read-first on collision.
module sdp_bram_be #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic [7:0]        wr_be,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [63:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [63:0]       rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [63:0] mem [DEPTH];

  // Non-blocking update of both ports gives old data on a same-word read.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    for (int b = 0; b < 8; b++) begin
      if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/axi_hp_responder.sv
// AXI3 slave standing in for PS HP0: serves INCR bursts from BRAM with programmable read latency.
//   state   | meaning
//   W_IDLE  | awready high, waiting for a write address
//   W_DATA  | wready high, one beat written per W handshake until awlen beats
//   W_RESP  | bvalid high with merged response until bready
//   R_IDLE  | arready high, waiting for a read address
//   R_WAIT  | RD_LATENCY idle cycles (skipped when zero)
//   R_FETCH | RAM read address driven for one cycle
//   R_DATA  | rvalid high with registered RAM data until rready
module axi_hp_responder
  import axi3_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned RD_LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  s_axi_awid,
  input  logic [31:0] s_axi_awaddr,
  input  logic [3:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [5:0]  s_axi_wid,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [5:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [5:0]  s_axi_arid,
  input  logic [31:0] s_axi_araddr,
  input  logic [3:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [5:0]  s_axi_rid,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;
  localparam logic [3:0]  LAT   = 4'(RD_LATENCY);

  // write channel
  w_state_t    w_state;
  logic [5:0]  w_id;
  logic [3:0]  w_len;
  logic [3:0]  w_beat;
  logic [31:0] w_addr;
  logic        w_burst_err;
  logic [1:0]  w_resp_acc;
  logic        w_hs;
  logic        w_dec;
  logic        w_last_beat;
  logic        w_chan_err;
  logic [1:0]  w_beat_resp;

  // read channel
  r_state_t    r_state;
  logic [5:0]  r_id;
  logic [3:0]  r_len;
  logic [3:0]  r_beat;
  logic [31:0] r_addr;
  logic        r_burst_err;
  logic [3:0]  r_cnt;
  logic        r_data_ok;
  logic        r_dec;

  // RAM ports
  logic [7:0]        ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [63:0]       ram_q;

  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign w_dec       = beat_out_of_range(w_addr, BASE_ADDR, DEPTH);
  assign w_last_beat = (w_beat == w_len);
  assign w_chan_err  = (s_axi_wlast != w_last_beat) || (s_axi_wid != w_id);

  always_comb begin
    w_beat_resp = RESP_OKAY;
    if (w_dec)                         w_beat_resp = RESP_DECERR;
    else if (w_burst_err || w_chan_err) w_beat_resp = RESP_SLVERR;
  end

  // W-channel protocol errors still commit data; only bad bursts and out-of-range beats do not.
  assign ram_we    = (w_hs && !w_burst_err && !w_dec && !rst_i) ? s_axi_wstrb : 8'h00;
  assign ram_waddr = ADDR_W'((w_addr - BASE_ADDR) >> 3);

  assign r_dec     = beat_out_of_range(r_addr, BASE_ADDR, DEPTH);
  assign ram_re    = (r_state == R_FETCH);
  assign ram_raddr = ADDR_W'((r_addr - BASE_ADDR) >> 3);

  assign s_axi_rdata = r_data_ok ? ram_q : 64'h0;

  sdp_bram_be #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_i),
    .wr_be   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (s_axi_wdata),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= 6'd0;
      s_axi_bresp   <= RESP_OKAY;
      w_id          <= 6'd0;
      w_len         <= 4'd0;
      w_beat        <= 4'd0;
      w_addr        <= 32'd0;
      w_burst_err   <= 1'b0;
      w_resp_acc    <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_id          <= s_axi_awid;
            w_len         <= s_axi_awlen;
            w_addr        <= s_axi_awaddr;
            w_beat        <= 4'd0;
            w_burst_err   <= (s_axi_awsize != SIZE_8B) || (s_axi_awburst != BURST_INCR);
            w_resp_acc    <= RESP_OKAY;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr     <= w_addr + 32'd8;
            w_beat     <= w_beat + 4'd1;
            w_resp_acc <= resp_merge(w_resp_acc, w_beat_resp);
            // Burst length comes from awlen alone; wlast only feeds the response.
            if (w_last_beat) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id;
              s_axi_bresp  <= resp_merge(w_resp_acc, w_beat_resp);
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= 6'd0;
      s_axi_rresp   <= RESP_OKAY;
      r_data_ok     <= 1'b0;
      r_id          <= 6'd0;
      r_len         <= 4'd0;
      r_beat        <= 4'd0;
      r_addr        <= 32'd0;
      r_burst_err   <= 1'b0;
      r_cnt         <= 4'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            r_id          <= s_axi_arid;
            r_len         <= s_axi_arlen;
            r_addr        <= s_axi_araddr;
            r_beat        <= 4'd0;
            r_burst_err   <= (s_axi_arsize != SIZE_8B) || (s_axi_arburst != BURST_INCR);
            r_cnt         <= LAT - 4'd1;
            r_state       <= (LAT == 4'd0) ? R_FETCH : R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) r_state <= R_FETCH;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        R_FETCH: begin
          s_axi_rvalid <= 1'b1;
          s_axi_rid    <= r_id;
          s_axi_rlast  <= (r_beat == r_len);
          if (r_dec)            s_axi_rresp <= RESP_DECERR;
          else if (r_burst_err) s_axi_rresp <= RESP_SLVERR;
          else                  s_axi_rresp <= RESP_OKAY;
          r_data_ok <= !(r_dec || r_burst_err);
          r_state   <= R_DATA;
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            if (r_beat == r_len) begin
              r_data_ok     <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_beat  <= r_beat + 4'd1;
              r_addr  <= r_addr + 32'd8;
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_hp_responder.sv
// Randomized and directed bench for axi_hp_responder against a word-array reference model.
module tb_axi_hp_responder;

  localparam int          ADDR_W = 8;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          LAT    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [3:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [5:0]  wid = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [5:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [5:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [3:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [5:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  // second instance with zero read latency; write side idle
  logic        ar2_valid = 1'b0;
  logic        ar2_ready;
  logic        aw2_ready, w2_ready, b2_valid, r2_rlast, r2_valid;
  logic [5:0]  b2_bid, r2_rid;
  logic [1:0]  b2_bresp, r2_rresp;
  logic [63:0] r2_rdata;
  logic        rready2 = 1'b1;

  axi_hp_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .RD_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wid(wid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  axi_hp_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .RD_LATENCY(0)) dut_lat0 (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awid(6'd0), .s_axi_awaddr(32'd0), .s_axi_awlen(4'd0), .s_axi_awsize(3'd0),
    .s_axi_awburst(2'd0), .s_axi_awvalid(1'b0), .s_axi_awready(aw2_ready),
    .s_axi_wid(6'd0), .s_axi_wdata(64'd0), .s_axi_wstrb(8'd0), .s_axi_wlast(1'b0),
    .s_axi_wvalid(1'b0), .s_axi_wready(w2_ready),
    .s_axi_bid(b2_bid), .s_axi_bresp(b2_bresp), .s_axi_bvalid(b2_valid), .s_axi_bready(1'b1),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(ar2_valid), .s_axi_arready(ar2_ready),
    .s_axi_rid(r2_rid), .s_axi_rdata(r2_rdata), .s_axi_rresp(r2_rresp), .s_axi_rlast(r2_rlast),
    .s_axi_rvalid(r2_valid), .s_axi_rready(rready2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: one 64-bit word per location
  logic [63:0] model [DEPTH];
  logic [63:0] wq_data [16];
  logic [7:0]  wq_strb [16];

  function automatic bit beat_dec(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) / 32'd8;
    return (a < BASE) || (off >= 32'(DEPTH));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 32'd8);
  endfunction

  task automatic write_burst(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int last_at,
                             input logic [5:0] w_id, input int b_hold, input string tag);
    bit bad_burst, serr, derr;
    int guard, w_to, w;
    logic [31:0] a;
    logic [1:0] exp_resp;
    bad_burst = (size != 3'b011) || (burst != 2'b01);
    serr = bad_burst || (w_id != id) || (last_at != int'(len));
    derr = 1'b0;
    w_to = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 50) begin @(posedge clk); #1; guard++; end
    check_eq({tag, ":awready"}, awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 32'(8 * i);
      wid = w_id; wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = (i == last_at); wvalid = 1'b1;
      guard = 0;
      while (!wready && guard < 50) begin @(posedge clk); #1; guard++; end
      if (!wready) w_to++;
      @(posedge clk); #1;
      if (beat_dec(a)) derr = 1'b1;
      else if (!bad_burst) begin
        w = word_of(a);
        for (int b = 0; b < 8; b++)
          if (wq_strb[i][b]) model[w][8*b +: 8] = wq_data[i][8*b +: 8];
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    check_eq({tag, ":wready_to"}, w_to, 0);
    bready = 1'b0;
    guard = 0;
    while (!bvalid && guard < 50) begin @(posedge clk); #1; guard++; end
    check_eq({tag, ":bvalid"}, bvalid, 1'b1);
    for (int k = 0; k < b_hold; k++) begin
      @(posedge clk); #1;
      check_eq({tag, ":b_hold"}, {bvalid, awready}, 2'b10);
    end
    exp_resp = derr ? 2'b11 : (serr ? 2'b10 : 2'b00);
    check_eq({tag, ":bresp"}, bresp, exp_resp);
    check_eq({tag, ":bid"}, bid, id);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic read_burst(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int stall_at,
                            input bit rand_rdy, input bit chk_lat, input string tag);
    bit bad_burst, holding;
    int t0, beat, guard, stall;
    logic [31:0] a;
    logic [1:0] exp_r;
    logic [63:0] exp_d;
    logic [66:0] held;
    bad_burst = (size != 3'b011) || (burst != 2'b01);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 50) begin @(posedge clk); #1; guard++; end
    check_eq({tag, ":arready"}, arready, 1'b1);
    t0 = cyc;
    @(posedge clk); #1;
    arvalid = 1'b0;
    beat = 0; guard = 0; stall = 0; holding = 1'b0; held = '0;
    while (beat <= int'(len) && guard < 400) begin
      if (beat == stall_at && stall < 5 && rvalid) begin
        rready = 1'b0; stall++;
      end else if (rand_rdy) rready = ($urandom_range(0, 2) != 0);
      else rready = 1'b1;
      if (holding) check_eq({tag, ":r_stable"}, {rvalid, rlast, rresp, rdata}, {1'b1, held});
      holding = rvalid && !rready;
      held = {rlast, rresp, rdata};
      if (rvalid && rready) begin
        a = addr + 32'(8 * beat);
        exp_r = beat_dec(a) ? 2'b11 : (bad_burst ? 2'b10 : 2'b00);
        exp_d = 64'h0;
        if (exp_r == 2'b00) exp_d = model[word_of(a)];
        check_eq({tag, ":rdata"}, rdata, exp_d);
        check_eq({tag, ":rresp/rlast/rid"}, {rresp, rlast, rid}, {exp_r, beat == int'(len), id});
        if (chk_lat) check_eq({tag, ":latency"}, cyc - t0, LAT + 2 + 2 * beat);
        beat++;
      end
      @(posedge clk); #1;
      guard++;
    end
    rready = 1'b0;
    check_eq({tag, ":beats"}, beat, int'(len) + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, guard;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {awready, wready, arready}, 3'b000);
    check_eq("rst_valid", {bvalid, rvalid, rlast}, 3'b000);
    check_eq("rst_payload", {bid, bresp, rid, rresp}, 16'h0);
    check_eq("rst_rdata", rdata, 64'h0);
    check_eq("rst_lat0_wr", {b2_valid, w2_ready, b2_bid, b2_bresp}, 10'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_ready", {awready, arready, aw2_ready}, 3'b111);

    // fill the whole memory so every read has a known expectation
    for (int blk = 0; blk < DEPTH / 16; blk++) begin
      for (int i = 0; i < 16; i++) begin wq_data[i] = {$urandom, $urandom}; wq_strb[i] = 8'hFF; end
      write_burst(6'(blk), BASE + 32'(blk * 128), 4'd15, 3'd3, 2'd1, 15, 6'(blk), 0, "init");
    end

    // basic burst, plus latency of each beat
    for (int i = 0; i < 4; i++) begin wq_data[i] = 64'h1111_1111_1111_1111 * 64'(i + 1); wq_strb[i] = 8'hFF; end
    write_burst(6'd5, BASE + 32'h40, 4'd3, 3'd3, 2'd1, 3, 6'd5, 0, "t1_wr");
    read_burst(6'd9, BASE + 32'h40, 4'd3, 3'd3, 2'd1, -1, 1'b0, 1'b1, "t1_rd");

    // byte lanes
    wq_data[0] = 64'h0; wq_strb[0] = 8'hFF;
    write_burst(6'd1, BASE, 4'd0, 3'd3, 2'd1, 0, 6'd1, 0, "t2_clr");
    wq_data[0] = 64'hAABBCCDD_EEFF0011; wq_strb[0] = 8'h0F;
    write_burst(6'd1, BASE, 4'd0, 3'd3, 2'd1, 0, 6'd1, 0, "t2_wr");
    read_burst(6'd2, BASE, 4'd0, 3'd3, 2'd1, -1, 1'b0, 1'b0, "t2_rd");

    // backpressure
    read_burst(6'd2, BASE + 32'h80, 4'd7, 3'd3, 2'd1, 3, 1'b0, 1'b0, "t3_rd");
    for (int i = 0; i < 2; i++) begin wq_data[i] = {$urandom, $urandom}; wq_strb[i] = 8'hFF; end
    write_burst(6'd3, BASE + 32'h180, 4'd1, 3'd3, 2'd1, 1, 6'd3, 3, "t3_wr");

    // error rules
    for (int i = 0; i < 4; i++) begin wq_data[i] = {$urandom, $urandom}; wq_strb[i] = 8'hFF; end
    write_burst(6'd4, BASE + 32'h100, 4'd1, 3'd2, 2'd1, 1, 6'd4, 0, "t4_size");
    read_burst(6'd4, BASE + 32'h100, 4'd1, 3'd3, 2'd1, -1, 1'b0, 1'b0, "t4_size_rd");
    read_burst(6'd6, BASE + 32'(DEPTH * 8 - 8), 4'd1, 3'd3, 2'd1, -1, 1'b0, 1'b0, "t4_top_rd");
    write_burst(6'd7, BASE + 32'h20, 4'd3, 3'd3, 2'd1, 1, 6'd7, 0, "t4_early_wlast");
    write_burst(6'd7, BASE + 32'h60, 4'd1, 3'd3, 2'd1, 99, 6'd7, 0, "t4_no_wlast");
    write_burst(6'd8, BASE + 32'h90, 4'd0, 3'd3, 2'd1, 0, 6'd9, 0, "t4_wid");
    read_burst(6'd8, BASE + 32'h20, 4'd7, 3'd3, 2'd1, -1, 1'b1, 1'b0, "t4_w_rd");
    write_burst(6'd10, BASE - 32'd8, 4'd1, 3'd3, 2'd1, 1, 6'd10, 0, "t4_below_wr");
    read_burst(6'd11, BASE - 32'd8, 4'd1, 3'd3, 2'd1, -1, 1'b0, 1'b0, "t4_below_rd");
    read_burst(6'd12, BASE + 32'h40, 4'd2, 3'd3, 2'd2, -1, 1'b0, 1'b0, "t4_wrap_rd");

    // zero-latency instance: first beat two cycles after AR
    araddr = BASE - 32'd16; arlen = 4'd1; arsize = 3'd3; arburst = 2'd1; arid = 6'h21;
    ar2_valid = 1'b1;
    guard = 0;
    while (!ar2_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    check_eq("lat0_arready", ar2_ready, 1'b1);
    t0 = cyc;
    @(posedge clk); #1;
    ar2_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      guard = 0;
      while (!r2_valid && guard < 20) begin @(posedge clk); #1; guard++; end
      check_eq("lat0_cycle", cyc - t0, 2 + 2 * b);
      check_eq("lat0_beat", {r2_rid, r2_rresp, r2_rlast, r2_rdata}, {6'h21, 2'b11, b == 1, 64'h0});
      @(posedge clk); #1;
    end

    // reset mid write
    awid = 6'd3; awaddr = BASE + 32'h200; awlen = 4'd3; awsize = 3'd3; awburst = 2'd1; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wid = 6'd3; wdata = {$urandom, $urandom}; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      guard = 0;
      while (!wready && guard < 20) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1;
      model[64 + i] = wdata;
    end
    wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_wr_rst", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_wr_release", {awready, arready}, 2'b11);

    // reset mid read
    arid = 6'd7; araddr = BASE + 32'h300; arlen = 4'd3; arsize = 3'd3; arburst = 2'd1; arvalid = 1'b1;
    rready = 1'b0;
    guard = 0;
    while (!arready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    guard = 0;
    while (!rvalid && guard < 30) begin @(posedge clk); #1; guard++; end
    check_eq("t6_rvalid_before", rvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_rd_rst", {bvalid, rvalid, rlast, arready, rid, rresp, rdata}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_rd_release", {awready, arready}, 2'b11);
    read_burst(6'd13, BASE + 32'h200, 4'd3, 3'd3, 2'd1, -1, 1'b0, 1'b0, "t6_readback");

    // randomized traffic
    for (int it = 0; it < 12; it++) begin
      logic [31:0] a;
      logic [3:0]  l;
      logic [5:0]  id;
      id = 6'($urandom);
      l  = 4'($urandom);
      a  = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd8;
      if (it % 5 == 4) a = BASE - 32'd8 * 32'($urandom_range(1, 3));
      for (int i = 0; i < 16; i++) begin wq_data[i] = {$urandom, $urandom}; wq_strb[i] = 8'($urandom); end
      write_burst(id, a, l, 3'd3, 2'd1, int'(l), id, int'($urandom_range(0, 2)), "rnd_wr");
      read_burst(6'($urandom), a, l, 3'd3, 2'd1, -1, 1'b1, 1'b0, "rnd_rd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
